// File: rtl/pipe_buffer_stage.sv
// Flushable pipeline stage with valid/allowin handshake.
// DEPTH=1 acts as a stage register; larger DEPTH gives a FIFO skid buffer.
module pipe_buffer_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             validin,
    input  logic [WIDTH-1:0] datain,
    output logic             allowin,
    input  logic             readygo,
    input  logic             cancel,
    input  logic             flush,
    input  logic             allowout,
    output logic             validout,
    output logic [WIDTH-1:0] dataout,
    output logic [CW-1:0]    count,
    output logic             valid
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             empty;
    logic             full;
    logic             push;
    logic             deq;

    // Pointers stay at 0 when there is a single entry.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (DEPTH == 1)
            return '0;
        else
            return p + 1'b1;
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign valid    = ~empty;
    assign allowin  = ~full | (readygo & allowout);
    assign validout = ~empty & readygo & ~cancel & ~flush;
    assign dataout  = mem[rd_ptr];
    assign push     = validin & allowin & ~flush;
    assign deq      = ~empty & ~flush & (cancel | (readygo & allowout));

    // Occupancy: flush empties, otherwise add pushes and remove dequeues.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
        end else begin
            unique case ({push, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Read/write pointers, both rewound by flush.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (deq)
                rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    // Entry storage; cleared on reset so dataout reads 0 afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= datain;
        end
    end

endmodule

// File: tb/tb_pipe_buffer_stage.sv
// Bench for pipe_buffer_stage: DEPTH 1/4/2 instances share one stimulus
// stream and are each compared against a queue-based reference model.
module tb_pipe_buffer_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        validin;
    logic [31:0] datain;
    logic        readygo;
    logic        cancel;
    logic        flush;
    logic        allowout;

    logic        ain  [3];
    logic        vout [3];
    logic        vld  [3];
    logic [31:0] dout [3];
    logic [0:0]  cnt1;
    logic [2:0]  cnt4;
    logic [1:0]  cnt2;

    int          depth [3] = '{1, 4, 2};
    logic [31:0] mq [3][$];
    int          vec  = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    pipe_buffer_stage #(.WIDTH(32), .DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst), .validin(validin), .datain(datain),
        .allowin(ain[0]), .readygo(readygo), .cancel(cancel),
        .flush(flush), .allowout(allowout), .validout(vout[0]),
        .dataout(dout[0]), .count(cnt1), .valid(vld[0])
    );

    pipe_buffer_stage #(.WIDTH(32), .DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst), .validin(validin), .datain(datain),
        .allowin(ain[1]), .readygo(readygo), .cancel(cancel),
        .flush(flush), .allowout(allowout), .validout(vout[1]),
        .dataout(dout[1]), .count(cnt4), .valid(vld[1])
    );

    pipe_buffer_stage #(.WIDTH(32), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .validin(validin), .datain(datain),
        .allowin(ain[2]), .readygo(readygo), .cancel(cancel),
        .flush(flush), .allowout(allowout), .validout(vout[2]),
        .dataout(dout[2]), .count(cnt2), .valid(vld[2])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] getcnt(input int i);
        case (i)
            0:       return 32'(cnt1);
            1:       return 32'(cnt4);
            default: return 32'(cnt2);
        endcase
    endfunction

    // One clock: check outputs mid-cycle, then advance the model at the edge.
    task automatic cyc();
        int   n [3];
        logic ea;
        logic ev;
        logic dq;
        logic ps;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n[i] = mq[i].size();
            ea = (n[i] != depth[i]) || (readygo && allowout);
            ev = (n[i] > 0) && readygo && !cancel && !flush;
            chk($sformatf("d%0d.allowin", depth[i]), 32'(ain[i]), 32'(ea));
            chk($sformatf("d%0d.validout", depth[i]), 32'(vout[i]), 32'(ev));
            chk($sformatf("d%0d.count", depth[i]), getcnt(i), n[i]);
            chk($sformatf("d%0d.valid", depth[i]), 32'(vld[i]), 32'(n[i] > 0));
            if (ev)
                chk($sformatf("d%0d.dataout", depth[i]), dout[i], mq[i][0]);
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (rst || flush) begin
                mq[i].delete();
            end else begin
                ea = (n[i] != depth[i]) || (readygo && allowout);
                ps = validin && ea;
                dq = (n[i] > 0) && (cancel || (readygo && allowout));
                if (dq)
                    void'(mq[i].pop_front());
                if (ps)
                    mq[i].push_back(datain);
            end
        end
        #1;
    endtask

    task automatic chk_reset_state();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d.rst_dataout", depth[i]), dout[i], 32'h0);
            chk($sformatf("d%0d.rst_count", depth[i]), getcnt(i), 32'h0);
            chk($sformatf("d%0d.rst_allowin", depth[i]), 32'(ain[i]), 32'h1);
            chk($sformatf("d%0d.rst_validout", depth[i]), 32'(vout[i]), 32'h0);
        end
    endtask

    initial begin
        rst = 1'b1; validin = 1'b0; datain = '0; readygo = 1'b0;
        cancel = 1'b0; flush = 1'b0; allowout = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        chk_reset_state();

        // Back-to-back stream starting with 0xA5.
        readygo = 1'b1; allowout = 1'b1; validin = 1'b1;
        for (int k = 0; k < 9; k++) begin
            datain = (k == 0) ? 32'hA5 : 32'(k);
            cyc();
        end
        validin = 1'b0;
        repeat (3) cyc();

        // Fill while blocked, then drain; 5 enters on the first pop cycle.
        allowout = 1'b0; validin = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            datain = 32'(k);
            cyc();
        end
        allowout = 1'b1;
        cyc();
        validin = 1'b0;
        repeat (6) cyc();

        // Full with simultaneous push and pop: pointers wrap.
        validin = 1'b1;
        for (int k = 0; k < 12; k++) begin
            datain   = 32'h30 + 32'(k);
            allowout = (k >= 2);
            cyc();
        end
        validin = 1'b0;
        repeat (6) cyc();

        // Cancel head 0x7; 0x8 follows.
        allowout = 1'b0; validin = 1'b1;
        datain = 32'h7; cyc();
        datain = 32'h8; cyc();
        validin = 1'b0; cancel = 1'b1; cyc();
        cancel = 1'b0; allowout = 1'b1;
        repeat (4) cyc();

        // Flush with entries held and an incoming word.
        allowout = 1'b0; validin = 1'b1;
        for (int k = 0; k < 3; k++) begin
            datain = 32'h50 + 32'(k);
            cyc();
        end
        datain = 32'h5F; flush = 1'b1; cyc();
        flush = 1'b0; validin = 1'b0; allowout = 1'b1;
        repeat (3) cyc();

        // Reset mid-operation.
        allowout = 1'b0; validin = 1'b1;
        datain = 32'h61; cyc();
        datain = 32'h62; cyc();
        validin = 1'b0; rst = 1'b1; cyc();
        rst = 1'b0;
        chk_reset_state();
        cyc();

        // Random traffic.
        for (int k = 0; k < 1500; k++) begin
            validin  = ($urandom_range(0, 3) != 0);
            datain   = $urandom;
            readygo  = ($urandom_range(0, 4) != 0);
            allowout = ($urandom_range(0, 9) < 7);
            cancel   = ($urandom_range(0, 11) == 0);
            flush    = ($urandom_range(0, 24) == 0);
            rst      = ($urandom_range(0, 99) == 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
